dec_sched: RTL and testbench
============================

# dec_sched

Round-robin job controller sharing one `decoder` instance between two requesters. Each requester submits a received string and a size code. The controller dispatches one job at a time to the decoder, holding its inputs stable, and waits for `done`. It then returns the masked decoded word with the requester id and an error code through a single-entry response register.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum BUSY cycles before abort; used only with the timeout feature.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester job valid; bit i is requester i.
- `req_ready` out 2: per-requester accept.
- `req_rstring` in 28: requester i string at `[14*i+13:14*i]`, right-justified.
- `req_size` in 6: requester i size code at `[3*i+2:3*i]`.
- `resp_valid` out 1: response register full.
- `resp_ready` in 1: response consumed when high with `resp_valid`.
- `resp_id` out 1: requester that owns the response.
- `resp_data` out 7: decoded word, zero above the payload width.
- `resp_err` out 2: 00 ok, 01 illegal size, 10 timeout.
- `dec_enable` out 1: decoder enable.
- `dec_size` out 3: decoder size.
- `dec_rstring` out 14: decoder input string.
- `dec_dstring` in 7: decoder output.
- `dec_done` in 1: decoder done.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Size map (code → string bits/payload bits):
  - 0 → 6/3
  - 1 → 8/4
  - 2 → 10/5
  - 3 → 14/7
  - 4–7 → illegal
- States:
  - IDLE → LOAD: on accept of a legal job.
  - IDLE → IDLE: illegal job; the error response is written directly.
  - LOAD → BUSY: unconditional.
  - BUSY → GAP: on `dec_done` high, or on timeout.
  - GAP → IDLE: unconditional.
- Acceptance: `req_ready` is nonzero only in IDLE with `resp_valid`=0. At most one bit is high: the arbitration winner.
- Arbitration: round-robin on the `last` pointer.
  - Both valid: the requester not equal to `last` wins.
  - One valid: that requester wins.
  - `last` updates on every accept, including illegal jobs.
- Dispatch: on accept, latch size, id and string, with string bits above 2·payload width forced to 0.
- Decoder drive: `dec_size`/`dec_rstring` hold the latched values in LOAD and BUSY. `dec_enable`=1 in LOAD and BUSY, 0 in IDLE and GAP.
- Completion: on the BUSY edge with `dec_done`=1:
  - `resp_data` ← `dec_dstring` masked to the payload width;
  - `resp_err`=00, `resp_id` ← latched id, `resp_valid` ← 1.
- GAP: one cycle with `dec_enable`=0, so the decoder restarts cleanly before the next job.
- Illegal size: no dispatch. `resp_data`=0, `resp_err`=01, `resp_valid` ← 1 on the accept edge.
- Response: `resp_valid` clears on the edge where `resp_ready`=1. A new job is never accepted in that same cycle; acceptance resumes the following cycle.

## Timing
- Reset values:
  - state IDLE, `last`=1 (requester 0 first);
  - `req_ready`=00, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=00;
  - `dec_enable`=0, `dec_size`=0, `dec_rstring`=0, `busy`=0.
- Legal job accepted at edge T:
  - LOAD in cycle T+1; decoder inputs valid in T+1.
  - BUSY from T+2.
  - If `dec_done` is sampled at edge D: `resp_valid`=1 from D+1, GAP in D+1, IDLE at D+2.
  - Earliest next accept at edge D+2, given the response was consumed.
- `dec_done` sampled in LOAD is ignored.
- Illegal job accepted at edge T: `resp_valid`=1 in T+1; state stays IDLE.
- Reset mid-job: all outputs return to reset values on the reset edge. The pending response and the in-flight job are discarded. The decoder sees `dec_enable`=0 the next cycle.

## Configuration
- Macro: `DEC_SCHED_TIMEOUT_EN`.
- Defined:
  - a counter runs in BUSY, cleared on entry;
  - when it reaches `TIMEOUT_CYCLES` without `dec_done`: `resp_err`=10, `resp_data`=0, `resp_valid` ← 1, state → GAP;
  - `dec_done` and timeout on the same edge: `dec_done` wins.
- Undefined: no counter and no parameter use. BUSY waits for `dec_done` indefinitely.

## Structure
- Package `dec_sched_pkg`:
  - state enum (IDLE, LOAD, BUSY, GAP);
  - error code constants;
  - `RS_W`=14, `DS_W`=7;
  - functions mapping size code → string width, payload width and legality.
- Sub-module `dec_sched_rr_arb`: 2-input round-robin arbiter.
  - Inputs: `req`, `last`, `en`.
  - Outputs: one-hot `grant`, `grant_id`.

## Test plan
Decoder is a stub: it returns `dec_dstring`=7'h7F with `dec_done` pulsed 5 cycles after `dec_enable` rises.
- Requester 0, size 0, rstring 6'b110110 → `dec_rstring`=14'b00000000110110. Response `resp_id`=0, `resp_data`=7'h07, `resp_err`=00, `resp_valid` at accept+8.
- Both requesters valid from reset, size 3 and size 1 → accepted in order 0, 1, 0, 1. Response data is 7'h7F and 7'h0F.
- Requester 1, size 5 → `resp_err`=01 and `resp_data`=0 in the cycle after accept. `dec_enable` never rises.
- `resp_ready` held 0 for 10 cycles after the first response → `req_ready`=00 throughout. The next accept occurs the cycle after `resp_ready`=1.
- Macro defined, `TIMEOUT_CYCLES`=8, stub never asserts done → `resp_err`=10 after 8 BUSY cycles. `dec_enable`=0 for one GAP cycle.
- `rst` asserted in BUSY → next cycle: all outputs at reset values, `resp_valid`=0, requester 0 has priority.

Source files
------------

// File: rtl/dec_sched_pkg.sv
// dec_sched_pkg: shared types, constants and size-code helpers for dec_sched.
//   state_t      - controller FSM state (IDLE, LOAD, BUSY, GAP)
//   ERR_*        - response error codes
//   RS_W / DS_W  - decoder received-string and decoded-word widths
//   size_legal / str_width / pay_width / str_mask / pay_mask
//                - size code to legality, widths and bit masks
package dec_sched_pkg;

    localparam int RS_W = 14;
    localparam int DS_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SIZE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Codes 4..7 have no decoder mode.
    function automatic logic size_legal(input logic [2:0] size);
        return size < 3'd4;
    endfunction

    function automatic int str_width(input logic [2:0] size);
        case (size)
            3'd0:    return 6;
            3'd1:    return 8;
            3'd2:    return 10;
            3'd3:    return 14;
            default: return 0;
        endcase
    endfunction

    function automatic int pay_width(input logic [2:0] size);
        case (size)
            3'd0:    return 3;
            3'd1:    return 4;
            3'd2:    return 5;
            3'd3:    return 7;
            default: return 0;
        endcase
    endfunction

    // Keeps string bits below twice the payload width.
    function automatic logic [RS_W-1:0] str_mask(input logic [2:0] size);
        logic [RS_W-1:0] m;
        m = '0;
        for (int i = 0; i < RS_W; i++) m[i] = (i < 2 * pay_width(size));
        return m;
    endfunction

    function automatic logic [DS_W-1:0] pay_mask(input logic [2:0] size);
        logic [DS_W-1:0] m;
        m = '0;
        for (int i = 0; i < DS_W; i++) m[i] = (i < pay_width(size));
        return m;
    endfunction

endpackage

// File: rtl/dec_sched_rr_arb.sv
// dec_sched_rr_arb: 2-input round-robin arbiter.
//   req      in  2 : request per requester
//   last     in  1 : requester granted most recently
//   en       in  1 : grant allowed this cycle
//   grant    out 2 : one-hot grant (zero when disabled or no request)
//   grant_id out 1 : index of the granted requester
module dec_sched_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        // NOTE: outputs get a default first so no branch can leave them
        // unassigned, which is what would otherwise infer a latch.
        grant = 2'b00;
        if (en) begin
            // On contention the requester that did not win last time goes.
            if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
            else              grant = req;
        end
        grant_id = grant[1];
    end

endmodule

// File: rtl/dec_sched.sv
// dec_sched: round-robin job controller sharing one decoder between two
// requesters, with a single-entry response register.
// Optional feature: define DEC_SCHED_TIMEOUT_EN to abort a BUSY job after
// TIMEOUT_CYCLES cycles without dec_done (resp_err = 10).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid / req_ready    - per-requester job handshake (bit i = requester i)
//   req_rstring / req_size   - requester i string [14i+13:14i], size [3i+2:3i]
//   resp_valid / resp_ready  - response handshake
//   resp_id/resp_data/resp_err - owner, masked decoded word, error code
//   dec_enable/dec_size/dec_rstring - decoder drive
//   dec_dstring / dec_done   - decoder result
//   busy                     - controller not IDLE
module dec_sched
    import dec_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*RS_W-1:0] req_rstring,
    input  logic [5:0]      req_size,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [DS_W-1:0] resp_data,
    output logic [1:0]      resp_err,
    output logic            dec_enable,
    output logic [2:0]      dec_size,
    output logic [RS_W-1:0] dec_rstring,
    input  logic [DS_W-1:0] dec_dstring,
    input  logic            dec_done,
    output logic            busy
);

    state_t          state_q, state_d;
    logic            last_q;
    logic [2:0]      job_size_q;
    logic            job_id_q;
    logic [RS_W-1:0] job_str_q;

    logic [1:0]      grant;
    logic            grant_id;
    logic            arb_en;
    logic            accept;
    logic [2:0]      sel_size;
    logic [RS_W-1:0] sel_str;
    logic            legal;
    logic            done_hit;
    logic            tmo_hit;

    // Accepting only with an empty response register means a job can never
    // complete into an occupied slot; rst gating keeps req_ready low in reset.
    assign arb_en = (state_q == IDLE) && !resp_valid && !rst;

    dec_sched_rr_arb u_arb (
        .req      (req_valid),
        .last     (last_q),
        .en       (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_size  = grant_id ? req_size[5:3] : req_size[2:0];
    assign sel_str   = grant_id ? req_rstring[2*RS_W-1:RS_W] : req_rstring[RS_W-1:0];
    assign legal     = size_legal(sel_size);
    // dec_done outside BUSY (e.g. in LOAD) is ignored.
    assign done_hit  = (state_q == BUSY) && dec_done;

`ifdef DEC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts completed BUSY cycles; held at zero outside BUSY so every job
    // starts from zero.
    always_ff @(posedge clk) begin
        if (rst || state_q != BUSY) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Fires on the last allowed BUSY cycle; dec_done on that edge wins.
    assign tmo_hit = (state_q == BUSY) && !dec_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && legal) state_d = LOAD;
            LOAD:    state_d = BUSY;
            BUSY:    if (done_hit || tmo_hit) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job latch, arbitration pointer and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            job_size_q <= '0;
            job_id_q   <= 1'b0;
            job_str_q  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= ERR_OK;
        end else begin
            if (resp_valid && resp_ready) resp_valid <= 1'b0;

            if (accept) begin
                last_q <= grant_id;
                if (legal) begin
                    job_size_q <= sel_size;
                    job_id_q   <= grant_id;
                    job_str_q  <= sel_str & str_mask(sel_size);
                end else begin
                    // Illegal size never reaches the decoder.
                    resp_valid <= 1'b1;
                    resp_id    <= grant_id;
                    resp_data  <= '0;
                    resp_err   <= ERR_SIZE;
                end
            end

            if (done_hit) begin
                resp_valid <= 1'b1;
                resp_id    <= job_id_q;
                resp_data  <= dec_dstring & pay_mask(job_size_q);
                resp_err   <= ERR_OK;
            end else if (tmo_hit) begin
                resp_valid <= 1'b1;
                resp_id    <= job_id_q;
                resp_data  <= '0;
                resp_err   <= ERR_TIMEOUT;
            end
        end
    end

    // Decoder inputs are only presented while the decoder is enabled, so
    // GAP gives it one idle cycle to restart between jobs.
    assign dec_enable  = (state_q == LOAD) || (state_q == BUSY);
    assign dec_size    = dec_enable ? job_size_q : 3'd0;
    assign dec_rstring = dec_enable ? job_str_q  : '0;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dec_sched.sv
// tb_dec_sched: self-checking bench for dec_sched with a decoder stub that
// returns 7'h7F and pulses dec_done 5 counted cycles after enable rises.
// Timeout section is active when DEC_SCHED_TIMEOUT_EN is defined.
module tb_dec_sched;
    import dec_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [27:0] req_rstring = '0;
    logic [5:0]  req_size = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [6:0]  resp_data;
    logic [1:0]  resp_err;
    logic        dec_enable;
    logic [2:0]  dec_size;
    logic [13:0] dec_rstring;
    logic [6:0]  dec_dstring;
    logic        dec_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dec_sched #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rstring (req_rstring),
        .req_size    (req_size),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .dec_enable  (dec_enable),
        .dec_size    (dec_size),
        .dec_rstring (dec_rstring),
        .dec_dstring (dec_dstring),
        .dec_done    (dec_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Decoder stub.
    logic [3:0] stub_cnt = '0;
    logic       stub_done = 1'b0;
    logic       allow_done = 1'b1;
    logic       force_done = 1'b0;
    always @(posedge clk) begin
        if (!dec_enable) begin
            stub_cnt  <= '0;
            stub_done <= 1'b0;
        end else begin
            stub_cnt  <= stub_cnt + 1'b1;
            stub_done <= allow_done && (stub_cnt == 4'd5);
        end
    end
    assign dec_done    = stub_done | force_done;
    assign dec_dstring = 7'h7F;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected responses, popped when a response is consumed.
    typedef struct packed {
        logic       id;
        logic [6:0] data;
        logic [1:0] err;
    } resp_t;
    resp_t sb[$];

    function automatic resp_t mk(input logic id, input logic [6:0] data, input logic [1:0] err);
        resp_t r;
        r.id = id; r.data = data; r.err = err;
        return r;
    endfunction

    always @(negedge clk) begin : mon
        resp_t e;
        if (!rst && resp_valid && resp_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_id", resp_id, e.id);
                check("resp_data", resp_data, e.data);
                check("resp_err", resp_err, e.err);
            end
        end
    end

    typedef struct {
        logic        id;
        logic [2:0]  size;
        logic [13:0] rs;
        logic [13:0] exp_rs;
        logic [6:0]  exp_data;
        logic [1:0]  exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [2:0] size, input logic [13:0] rs);
        req_size    = '0;
        req_rstring = '0;
        if (id) begin req_size[5:3] = size; req_rstring[27:14] = rs; end
        else    begin req_size[2:0] = size; req_rstring[13:0]  = rs; end
        req_valid = id ? 2'b10 : 2'b01;
    endtask

    // Waits for resp_valid; returns edges elapsed since the caller's edge.
    task automatic wait_resp(input string name, output int n);
        n = 0;
        while (!resp_valid && n < 40) begin tick(); n++; end
        check(name, resp_valid, 1);
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_clear", resp_valid, 0);
    endtask

    task automatic run_job(input vec_t v);
        int n;
        drive(v.id, v.size, v.rs);
        #1;
        check("vec_req_ready", req_ready, v.id ? 2'b10 : 2'b01);
        tick();                       // accept edge T
        req_valid = 2'b00;
        sb.push_back(mk(v.id, v.exp_data, v.exp_err));
        if (v.exp_err == ERR_OK) begin
            check("load_enable", dec_enable, 1);
            check("load_size", dec_size, v.size);
            check("load_rstring", dec_rstring, v.exp_rs);
            check("load_busy", busy, 1);
            wait_resp("vec_resp", n);
            check("vec_latency", n, 7);
            check("gap_enable", dec_enable, 0);
            check("gap_busy", busy, 1);
            consume();
            check("idle_busy", busy, 0);
        end else begin
            check("ill_resp_valid", resp_valid, 1);
            check("ill_resp_err", resp_err, ERR_SIZE);
            check("ill_resp_data", resp_data, 0);
            check("ill_enable", dec_enable, 0);
            check("ill_busy", busy, 0);
            consume();
            check("ill_enable2", dec_enable, 0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int k;
        int cyc;

        vecs[0] = '{1'b0, 3'd0, 14'b00000000110110, 14'b00000000110110, 7'h07, ERR_OK};
        vecs[1] = '{1'b1, 3'd1, 14'h3FFF, 14'h00FF, 7'h0F, ERR_OK};
        vecs[2] = '{1'b0, 3'd2, 14'h3ABC, 14'h02BC, 7'h1F, ERR_OK};
        vecs[3] = '{1'b1, 3'd3, 14'h2A5C, 14'h2A5C, 7'h7F, ERR_OK};
        vecs[4] = '{1'b1, 3'd5, 14'h1234, 14'h0000, 7'h00, ERR_SIZE};
        vecs[5] = '{1'b0, 3'd7, 14'h3FFF, 14'h0000, 7'h00, ERR_SIZE};
        vecs[6] = '{1'b0, 3'd0, 14'h3FC9, 14'h0009, 7'h07, ERR_OK};

        // Reset values.
        tick(); tick();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_dec_enable", dec_enable, 0);
        check("rst_dec_size", dec_size, 0);
        check("rst_dec_rstring", dec_rstring, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        req_size    = {3'd1, 3'd3};
        req_rstring = {14'h3FFF, 14'h3FFF};
        req_valid   = 2'b11;
        resp_ready  = 1'b1;
        #1;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 200) begin
            if (req_ready != 2'b00) begin
                check("rr_grant", req_ready, k[0] ? 2'b10 : 2'b01);
                sb.push_back(k[0] ? mk(1'b1, 7'h0F, ERR_OK) : mk(1'b0, 7'h7F, ERR_OK));
                k++;
            end
            tick();
            cyc++;
        end
        req_valid = 2'b00;
        check("rr_accepts", k, 4);
        n = 0;
        while (sb.size() != 0 && n < 50) begin tick(); n++; end
        check("rr_drain", sb.size(), 0);
        resp_ready = 1'b0;
        tick();

        // Table-driven jobs.
        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Response back-pressure blocks acceptance.
        drive(1'b0, 3'd2, 14'h0155);
        tick();
        req_valid = 2'b00;
        sb.push_back(mk(1'b0, 7'h1F, ERR_OK));
        wait_resp("bp_resp", n);
        req_valid = 2'b01;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_ready_low", req_ready, 2'b00);
            tick();
        end
        check("bp_still_valid", resp_valid, 1);
        resp_ready = 1'b1;
        #1;
        check("bp_ready_same", req_ready, 2'b00);
        tick();
        resp_ready = 1'b0;
        check("bp_ready_next", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        sb.push_back(mk(1'b0, 7'h1F, ERR_OK));
        check("bp_accepted", dec_enable, 1);
        wait_resp("bp_resp2", n);
        check("bp_latency", n, 7);
        consume();
        tick();

        // dec_done during LOAD is ignored.
        drive(1'b1, 3'd3, 14'h1111);
        tick();                       // accept edge T
        req_valid  = 2'b00;
        sb.push_back(mk(1'b1, 7'h7F, ERR_OK));
        force_done = 1'b1;
        tick();                       // edge T+1 samples done in LOAD
        force_done = 1'b0;
        check("ld_done_enable", dec_enable, 1);
        check("ld_done_resp", resp_valid, 0);
        wait_resp("ld_done_resp2", n);
        check("ld_done_latency", n + 1, 7);
        consume();
        tick();

`ifdef DEC_SCHED_TIMEOUT_EN
        // Stub never finishes: abort after 8 BUSY cycles.
        allow_done = 1'b0;
        drive(1'b1, 3'd3, 14'h2222);
        tick();
        req_valid = 2'b00;
        sb.push_back(mk(1'b1, 7'h00, ERR_TIMEOUT));
        wait_resp("tmo_resp", n);
        check("tmo_latency", n, 9);
        check("tmo_err", resp_err, ERR_TIMEOUT);
        check("tmo_gap_enable", dec_enable, 0);
        check("tmo_gap_busy", busy, 1);
        consume();
        check("tmo_idle", busy, 0);
        allow_done = 1'b1;
        tick();
`endif

        // Reset while BUSY on a requester-0 job.
        drive(1'b0, 3'd1, 14'h00AA);
        tick();
        req_valid = 2'b00;
        sb.push_back(mk(1'b0, 7'h0F, ERR_OK));
        tick(); tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        sb.delete();
        check("mr_resp_valid", resp_valid, 0);
        check("mr_dec_enable", dec_enable, 0);
        check("mr_busy", busy, 0);
        check("mr_dec_size", dec_size, 0);
        check("mr_dec_rstring", dec_rstring, 0);
        check("mr_resp_data", resp_data, 0);
        check("mr_req_ready", req_ready, 2'b00);
        rst = 1'b0;
        req_size  = {3'd0, 3'd0};
        req_valid = 2'b11;
        #1;
        check("mr_priority", req_ready, 2'b01);
        req_valid = 2'b00;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
